// File: rtl/instr_encoder.sv
// instr_encoder
//   Reverse path of the immediate decoder: packs decoded instruction fields
//   into a 32-bit RV32I word, buffers the words in a small FIFO and tags each
//   one with a sequential instruction-memory address and an error bit.
//
//   Optional build macro: INSTR_ENCODER_RANGE_CHECK_EN
//     When defined, out_err is also raised for immediates that do not fit
//     their format. The word is still encoded from the truncated bits.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   field bundle handshake (in_ready = FIFO not full)
//   in_fmt              0=R 1=I 2=S 3=B 4=U 5=J, 6-7 invalid
//   in_opcode .. in_imm decoded fields
//   out_valid/out_ready encoded word handshake (FIFO head)
//   out_instr           encoded word
//   out_addr            address tagged to out_instr
//   out_err             encode error tagged to out_instr
//   count               FIFO occupancy
module instr_encoder #(
  parameter int unsigned          DEPTH     = 4,
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_fmt,
  input  logic [6:0]               in_opcode,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  logic [31:0]       mem_instr [DEPTH];
  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic              mem_err   [DEPTH];

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_next;
  logic [ADDR_W-1:0] addr_cnt;

  logic [31:0]       enc_word;
  logic              enc_err;
  logic              push;
  logic              pop;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign rd_next   = rd_ptr + 1'b1;

  // Combinational field packing
  always_comb begin
    logic signed [31:0] simm;
    logic               range_bad;
    simm      = $signed(in_imm);
    range_bad = 1'b0;
    enc_word  = '0;
    enc_err   = 1'b0;
    case (fmt_t'(in_fmt))
      FMT_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: begin
        enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        range_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      FMT_S: begin
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        range_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      FMT_B: begin
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        range_bad = (simm < -32'sd4096) || (simm > 32'sd4094) || in_imm[0];
      end
      FMT_U: begin
        enc_word  = {in_imm[31:12], in_rd, in_opcode};
        range_bad = (in_imm[11:0] != 12'd0);
      end
      FMT_J: begin
        enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        range_bad = (simm < -32'sd1048576) || (simm > 32'sd1048574) || in_imm[0];
      end
      default: begin
        enc_word = '0;
        enc_err  = 1'b1;
      end
    endcase
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    enc_err = enc_err | range_bad;
`else
    range_bad = 1'b0;
    enc_err   = enc_err | range_bad;
`endif
  end

  // FIFO storage plus registered head copy on out_*.
  // The head register is refreshed with whatever entry will sit at the head
  // after this edge: the next stored entry on a pop, or the incoming word when
  // it lands in an empty (or emptying) FIFO. Otherwise it holds, so out_* keeps
  // the last popped word once the FIFO drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      addr_cnt  <= BASE_ADDR;
      out_instr <= '0;
      out_addr  <= BASE_ADDR;
      out_err   <= 1'b0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= enc_word;
        mem_addr[wr_ptr]  <= addr_cnt;
        mem_err[wr_ptr]   <= enc_err;
        wr_ptr            <= wr_ptr + 1'b1;
        addr_cnt          <= addr_cnt + ADDR_W'(4);
      end

      if (pop) begin
        rd_ptr <= rd_next;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pop && (count > (PW+1)'(1))) begin
        out_instr <= mem_instr[rd_next];
        out_addr  <= mem_addr[rd_next];
        out_err   <= mem_err[rd_next];
      end else if (push && ((count == '0) || (pop && count == (PW+1)'(1)))) begin
        out_instr <= enc_word;
        out_addr  <= addr_cnt;
        out_err   <= enc_err;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
//   Directed bench for instr_encoder (DEPTH=4, BASE_ADDR=0x1000).
//   Expected words are hand-encoded RV32I values.
module tb_instr_encoder;

  localparam int unsigned    DEPTH  = 4;
  localparam int unsigned    ADDR_W = 32;
  localparam logic [31:0]    BASE   = 32'h0000_1000;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  localparam logic           RANGE_ERR = 1'b1;
`else
  localparam logic           RANGE_ERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic [2:0]        count;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] a;

  instr_encoder #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_fmt   (in_fmt),
    .in_opcode(in_opcode),
    .in_rd    (in_rd),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .in_funct3(in_funct3),
    .in_funct7(in_funct7),
    .in_imm   (in_imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_addr (out_addr),
    .out_err  (out_err),
    .count    (count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    set_fields(f, op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Check the head word, then pop it.
  task automatic head(input string tag, input logic [31:0] instr, input logic [31:0] addr,
                      input logic err);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_instr"}, out_instr, instr);
    chk({tag, "_addr"},  out_addr,  addr);
    chk({tag, "_err"},   32'(out_err), 32'(err));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_addr",  out_addr, BASE);
    chk("rst_err",   32'(out_err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Single words through an empty FIFO, one-cycle latency
    a = BASE;
    send(3'd1, 7'h13, 5'd10, 5'd10, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("i5_count", 32'(count), 32'd1);
    head("i5", 32'h0055_0513, a, 1'b0); a += 4;
    chk("empty_valid", 32'(out_valid), 32'd0);
    chk("empty_hold",  out_instr, 32'h0055_0513);

    send(3'd1, 7'h13, 5'd10, 5'd10, 5'd0, 3'd0, 7'd0, -32'sd7);
    head("im7", 32'hFF95_0513, a, 1'b0); a += 4;
    send(3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8);
    head("s8", 32'h0051_2423, a, 1'b0); a += 4;
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4);
    head("bm4", 32'hFE20_8EE3, a, 1'b0); a += 4;
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    head("j2048", 32'h0010_00EF, a, 1'b0); a += 4;
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF);
    head("r_sub", 32'h4020_81B3, a, 1'b0); a += 4;
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    head("u_lui", 32'h1234_52B7, a, 1'b0); a += 4;

    // Invalid format still consumes an address
    send(3'd7, 7'h13, 5'd10, 5'd10, 5'd0, 3'd0, 7'd0, 32'd5);
    head("fmt7", 32'h0000_0000, a, 1'b1); a += 4;
    send(3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    head("fmt6", 32'h0000_0000, a, 1'b1); a += 4;
    send(3'd1, 7'h13, 5'd10, 5'd10, 5'd0, 3'd0, 7'd0, 32'd5);
    head("after_inv", 32'h0055_0513, a, 1'b0); a += 4;

    // Out-of-range immediates: truncated encoding, error only with range check
    send(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    head("i2048", 32'h8000_0013, a, RANGE_ERR); a += 4;
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    head("b_odd", 32'h0020_8163, a, RANGE_ERR); a += 4;
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
    head("u_low", 32'h1234_52B7, a, RANGE_ERR); a += 4;
    send(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048);
    head("im2048", 32'h8000_0013, a, 1'b0); a += 4;

    // Backpressure: 5 back-to-back pushes into DEPTH=4 with out_ready=0
    set_fields(3'd1, 7'h13, 5'd10, 5'd10, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_imm = 32'(i);
      chk("bp_ready", 32'(in_ready), 32'd1);
      tick();
      chk("bp_count", 32'(count), 32'(i + 1));
    end
    in_imm = 32'd4;
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    tick();
    chk("bp_held_count", 32'(count), 32'd4);
    chk("bp_held_ready", 32'(in_ready), 32'd0);
    chk("bp_head", out_instr, 32'h0005_0513);
    // Full with in_valid and out_ready both high: pop only
    out_ready = 1'b1;
    tick();
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_pop_ready", 32'(in_ready), 32'd1);
    for (int k = 1; k < 5; k++) begin
      chk("drain_instr", out_instr, 32'h0005_0513 | (32'(k) << 20));
      chk("drain_addr",  out_addr,  a + 32'(4 * k));
      tick();
      in_valid = 1'b0;
      chk("drain_count", 32'(count), (k == 1) ? 32'd3 : 32'(4 - k));
    end
    out_ready = 1'b0;
    chk("drained_valid", 32'(out_valid), 32'd0);
    chk("drained_hold",  out_instr, 32'h0045_0513);
    a += 20;

    // Next word follows on directly
    send(3'd1, 7'h13, 5'd10, 5'd10, 5'd0, 3'd0, 7'd0, 32'd5);
    head("post_bp", 32'h0055_0513, a, 1'b0);

    // Reset mid-stream with handshakes active
    send(3'd1, 7'h13, 5'd10, 5'd10, 5'd0, 3'd0, 7'd0, 32'd1);
    send(3'd1, 7'h13, 5'd10, 5'd10, 5'd0, 3'd0, 7'd0, 32'd2);
    chk("pre_rst_count", 32'(count), 32'd2);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_instr", out_instr, 32'd0);
    chk("mid_rst_addr",  out_addr, BASE);
    send(3'd1, 7'h13, 5'd10, 5'd10, 5'd0, 3'd0, 7'd0, -32'sd7);
    head("post_rst", 32'hFF95_0513, BASE, 1'b0);
    chk("final_count", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
